operand_fetch: RTL



---
 rtl/operand_fetch.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Sequencing stage in front of the ALU. Each instruction takes four or more
// cycles:
//   FETCH  : request the word at PC and wait for it to come back.
//   READ_A : read source register ra through the single register-file port.
//   READ_B : read source register rb, or use the zero-extended immediate.
//   EXEC   : present the operands to the ALU for one cycle. Write the ALU
//            result back to rd and load the ALU's next-PC.
//
// Instruction word (WORD_W=32, OP_W=5, REG_AW=5):
//   [31:27] opcode  [26:22] rd  [21:17] ra  [16:12] rb  [11] imm  [10:0] imm11
// The field positions come from the parameters. The opcode sits at the top,
// followed by the three register indices and the imm flag. The immediate takes
// all remaining low bits.
//
// Register index 0 is hard-wired to zero. Reads of index 0 ignore rf_rdata,
// and writes to index 0 are suppressed.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   run              lets a new fetch start; only looked at in FETCH
//   imem_req/addr    instruction request (addr is always the PC)
//   imem_rdata/valid instruction return; accepted only in FETCH with run=1
//   rf_raddr/rdata   register-file read port (rdata is combinational)
//   rf_we/waddr/wdata register-file write port, active only in EXEC
//   operator, arg_a, arg_b, currpc
//                    registered ALU inputs; they update together on the edge
//                    that leaves READ_B and otherwise hold their values
//   alu_valid        high during the EXEC cycle
//   result, nxtpc    ALU outputs, consumed in EXEC
// -----------------------------------------------------------------------------
module operand_fetch #(
  parameter int                 WORD_W   = 32,
  parameter int                 OP_W     = 5,
  parameter int                 REG_AW   = 5,
  parameter logic [WORD_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,

  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_valid,

  output logic [REG_AW-1:0] rf_raddr,
  input  logic [WORD_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [WORD_W-1:0] rf_wdata,

  output logic [OP_W-1:0]   operator,
  output logic [WORD_W-1:0] arg_a,
  output logic [WORD_W-1:0] arg_b,
  output logic [WORD_W-1:0] currpc,
  output logic              alu_valid,
  input  logic [WORD_W-1:0] result,
  input  logic [WORD_W-1:0] nxtpc
);

  // ---------------------------------------------------------------------------
  // Instruction field layout, derived from the top of the word downwards.
  // ---------------------------------------------------------------------------
  localparam int OPC_LSB = WORD_W - OP_W;
  localparam int RD_LSB  = OPC_LSB - REG_AW;
  localparam int RA_LSB  = RD_LSB - REG_AW;
  localparam int RB_LSB  = RA_LSB - REG_AW;
  localparam int IMM_BIT = RB_LSB - 1;
  localparam int IMMV_W  = IMM_BIT;          // immediate occupies [IMM_BIT-1:0]

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    EXEC   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] ir;       // latched instruction word
  logic [WORD_W-1:0] a_q;      // operand A, held until all ALU inputs update

  // Decoded fields of the latched instruction.
  logic [OP_W-1:0]   dec_op;
  logic [REG_AW-1:0] dec_rd;
  logic [REG_AW-1:0] dec_ra;
  logic [REG_AW-1:0] dec_rb;
  logic              dec_imm;
  logic [WORD_W-1:0] dec_immv;

  assign dec_op   = ir[WORD_W-1 -: OP_W];
  assign dec_rd   = ir[RD_LSB +: REG_AW];
  assign dec_ra   = ir[RA_LSB +: REG_AW];
  assign dec_rb   = ir[RB_LSB +: REG_AW];
  assign dec_imm  = ir[IMM_BIT];
  assign dec_immv = {{(WORD_W-IMMV_W){1'b0}}, ir[IMMV_W-1:0]};

  assign imem_addr = pc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments, so all
  // registers sample their inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. imem_valid only matters in FETCH with run high. Any other
  // return is ignored.
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb block assigns a default to every output first, so
  // no path can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:   if (run && imem_valid) state_next = READ_A;
      READ_A:  state_next = READ_B;
      READ_B:  state_next = EXEC;
      EXEC:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. While rst is high, every strobe is forced low. This stops an
  // instruction caught in EXEC from writing the register file on the
  // resetting edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req  = 1'b0;
    rf_raddr  = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    alu_valid = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH:  imem_req = run;
        READ_A: rf_raddr = dec_ra;
        READ_B: rf_raddr = dec_rb;
        EXEC: begin
          alu_valid = 1'b1;
          rf_we     = (dec_rd != '0);
          rf_waddr  = dec_rd;
          rf_wdata  = result;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers.
  //   FETCH : capture the instruction when it is accepted.
  //   READ_A: capture operand A (index 0 reads as zero).
  //   READ_B: load all four ALU inputs at once, so they are stable
  //           through EXEC.
  //   EXEC  : take the ALU's next-PC; wrapping is inherent in WORD_W.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a_q      <= '0;
      operator <= '0;
      arg_a    <= '0;
      arg_b    <= '0;
      currpc   <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (run && imem_valid) ir <= imem_rdata;
        end
        READ_A: begin
          a_q <= (dec_ra == '0) ? '0 : rf_rdata;
        end
        READ_B: begin
          operator <= dec_op;
          arg_a    <= a_q;
          currpc   <= pc;
          if (dec_imm)             arg_b <= dec_immv;
          else if (dec_rb == '0)   arg_b <= '0;
          else                     arg_b <= rf_rdata;
        end
        EXEC: begin
          pc <= nxtpc;
        end
        default: ;
      endcase
    end
  end

endmodule
